// File: rtl/d_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d_mem_ctrl_pkg
//  Description : Shared size codes and FSM state encoding for the MEM-stage
//                data-access controller and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package d_mem_ctrl_pkg;

    // Access size encodings carried on mem_sizeM / data_size
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage : d_mem_ctrl_pkg
`default_nettype wire

// File: rtl/d_mem_ctrl_store_lane_rep.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_rep
//  Description : Replicates right-aligned store data across all byte lanes
//                according to the access size, so the bus slave can pick the
//                lane it needs from the low address bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_lane_rep
    import d_mem_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wdata_o
);

    // Lane replication by access size; word (and unused codes) pass through
    always_comb begin
        wdata_o = wdata_i;
        case (size_i)
            SIZE_B:  wdata_o = {4{wdata_i[7:0]}};
            SIZE_H:  wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

endmodule : store_lane_rep
`default_nettype wire

// File: rtl/d_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : d_mem_ctrl
//  Description : MEM-stage data-access controller. Turns the MEM-stage
//                load/store into a req/addr_ok/data_ok bus transaction,
//                stalls the pipeline while it is in flight and holds the
//                loaded word until the instruction leaves MEM.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_mem_ctrl
    import d_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_enM,
    input  logic              mem_write_enM,
    input  logic [1:0]        mem_sizeM,
    input  logic [ADDR_W-1:0] mem_addrM,
    input  logic [31:0]       mem_wdataM,
    input  logic              ext_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              d_cache_stall,
    output logic [31:0]       mem_rdataM
);

    state_e            state_q;
    state_e            state_d;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic              w_access;
    logic              w_issue;
    logic [1:0]        w_size;
    logic [31:0]       w_wdata_raw;

    assign w_access = mem_read_enM | mem_write_enM;
    // A fresh request goes out straight from the MEM-stage inputs in IDLE,
    // so the best case costs no extra cycle for latching.
    assign w_issue  = (state_q == ST_IDLE) && w_access;

    assign data_wr     = w_issue ? mem_write_enM : wr_q;
    assign w_size      = w_issue ? mem_sizeM     : size_q;
    assign data_size   = w_size;
    assign data_addr   = w_issue ? mem_addrM     : addr_q;
    assign w_wdata_raw = w_issue ? mem_wdataM    : wdata_q;
    assign mem_rdataM  = rdata_q;

    store_lane_rep u_store_lane_rep (
        .size_i  (w_size),
        .wdata_i (w_wdata_raw),
        .wdata_o (data_wdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, bus request and pipeline stall
    always_comb begin
        state_d       = state_q;
        data_req      = 1'b0;
        d_cache_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_access) begin
                    data_req      = 1'b1;
                    d_cache_stall = 1'b1;
                    state_d       = data_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                data_req      = 1'b1;
                d_cache_stall = 1'b1;
                if (data_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                d_cache_stall = 1'b1;
                if (data_data_ok) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Same instruction stays in MEM while frozen elsewhere; it is
                // never re-issued, so just wait for the pipeline to move.
                if (!ext_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields latched at issue so REQ/WAIT see a stable transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (w_issue) begin
            wr_q    <= mem_write_enM;
            size_q  <= mem_sizeM;
            addr_q  <= mem_addrM;
            wdata_q <= mem_wdataM;
        end
    end

    // Load data capture; held until the next load completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if ((state_q == ST_WAIT) && data_data_ok && !wr_q) begin
            rdata_q <= data_rdata;
        end
    end

endmodule : d_mem_ctrl
`default_nettype wire

// File: tb/tb_d_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_mem_ctrl
//  Description : Directed, table-driven bench for d_mem_ctrl plus hand-written
//                reset and idle-noise sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_mem_ctrl;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              mem_read_enM;
    logic              mem_write_enM;
    logic [1:0]        mem_sizeM;
    logic [ADDR_W-1:0] mem_addrM;
    logic [31:0]       mem_wdataM;
    logic              ext_stall;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              d_cache_stall;
    logic [31:0]       mem_rdataM;

    int checks = 0;
    int errors = 0;

    d_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_enM  (mem_read_enM),
        .mem_write_enM (mem_write_enM),
        .mem_sizeM     (mem_sizeM),
        .mem_addrM     (mem_addrM),
        .mem_wdataM    (mem_wdataM),
        .ext_stall     (ext_stall),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .d_cache_stall (d_cache_stall),
        .mem_rdataM    (mem_rdataM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ext;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic [31:0] e_rdm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rd, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ext, input logic aok, input logic dok,
                       input logic [31:0] rdata,
                       input logic e_req, input logic e_wr, input logic [1:0] e_size,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic e_stall, input logic [31:0] e_rdm);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.ext = ext; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.e_req = e_req; v.e_wr = e_wr; v.e_size = e_size; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_stall = e_stall; v.e_rdm = e_rdm;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, actual, expected);
        end
    endtask

    task automatic check_all(input int idx, input logic e_req, input logic e_wr,
                             input logic [1:0] e_size, input logic [31:0] e_addr,
                             input logic [31:0] e_wdata, input logic e_stall,
                             input logic [31:0] e_rdm);
        check("data_req",      idx, {31'd0, data_req},      {31'd0, e_req});
        check("data_wr",       idx, {31'd0, data_wr},       {31'd0, e_wr});
        check("data_size",     idx, {30'd0, data_size},     {30'd0, e_size});
        check("data_addr",     idx, data_addr,              e_addr);
        check("data_wdata",    idx, data_wdata,             e_wdata);
        check("d_cache_stall", idx, {31'd0, d_cache_stall}, {31'd0, e_stall});
        check("mem_rdataM",    idx, mem_rdataM,             e_rdm);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ext, input logic aok, input logic dok,
                         input logic [31:0] rdata);
        mem_read_enM = rd; mem_write_enM = wr; mem_sizeM = size;
        mem_addrM = addr; mem_wdataM = wdata; ext_stall = ext;
        data_addr_ok = aok; data_data_ok = dok; data_rdata = rdata;
    endtask

    initial begin
        //  rd wr sz addr          wdata         ext aok dok rdata
        //  req wr sz addr         wdata         stall rdataM
        // Load word, best case
        add(1,0,2,32'h0000_0100,32'h0,0,1,0,32'h0,          1,0,2,32'h0000_0100,32'h0,1,32'h0);
        add(1,0,2,32'h0000_0100,32'h0,0,0,1,32'hDEAD_BEEF,  0,0,2,32'h0000_0100,32'h0,1,32'h0);
        add(1,0,2,32'h0000_0100,32'h0,0,0,0,32'h0,          0,0,2,32'h0000_0100,32'h0,0,32'hDEAD_BEEF);
        // Store byte, addr_ok three cycles late; write data must not update rdataM
        add(0,1,0,32'h0000_0103,32'h5A,0,0,0,32'h0,         1,1,0,32'h0000_0103,32'h5A5A_5A5A,1,32'hDEAD_BEEF);
        add(0,1,0,32'h0000_0103,32'h5A,0,0,0,32'h0,         1,1,0,32'h0000_0103,32'h5A5A_5A5A,1,32'hDEAD_BEEF);
        add(0,1,0,32'h0000_0103,32'h5A,0,0,0,32'h0,         1,1,0,32'h0000_0103,32'h5A5A_5A5A,1,32'hDEAD_BEEF);
        add(0,1,0,32'h0000_0103,32'h5A,0,1,0,32'h0,         1,1,0,32'h0000_0103,32'h5A5A_5A5A,1,32'hDEAD_BEEF);
        add(0,1,0,32'h0000_0103,32'h5A,0,0,1,32'hFFFF_FFFF, 0,1,0,32'h0000_0103,32'h5A5A_5A5A,1,32'hDEAD_BEEF);
        add(0,1,0,32'h0000_0103,32'h5A,0,0,0,32'h0,         0,1,0,32'h0000_0103,32'h5A5A_5A5A,0,32'hDEAD_BEEF);
        // Load with REQ/WAIT latency, ext_stall in WAIT and three cycles in DONE
        add(1,0,2,32'h0000_0200,32'h0,0,0,0,32'h0,          1,0,2,32'h0000_0200,32'h0,1,32'hDEAD_BEEF);
        add(1,0,2,32'h0000_0200,32'h0,0,1,0,32'h0,          1,0,2,32'h0000_0200,32'h0,1,32'hDEAD_BEEF);
        add(1,0,2,32'h0000_0200,32'h0,1,0,0,32'h0,          0,0,2,32'h0000_0200,32'h0,1,32'hDEAD_BEEF);
        add(1,0,2,32'h0000_0200,32'h0,1,0,1,32'hCAFE_F00D,  0,0,2,32'h0000_0200,32'h0,1,32'hDEAD_BEEF);
        add(1,0,2,32'h0000_0200,32'h0,1,1,1,32'h1111_1111,  0,0,2,32'h0000_0200,32'h0,0,32'hCAFE_F00D);
        add(1,0,2,32'h0000_0200,32'h0,1,1,1,32'h2222_2222,  0,0,2,32'h0000_0200,32'h0,0,32'hCAFE_F00D);
        add(1,0,2,32'h0000_0200,32'h0,1,0,1,32'h3333_3333,  0,0,2,32'h0000_0200,32'h0,0,32'hCAFE_F00D);
        add(1,0,2,32'h0000_0200,32'h0,0,0,0,32'h0,          0,0,2,32'h0000_0200,32'h0,0,32'hCAFE_F00D);
        // Load immediately followed by store half
        add(1,0,2,32'h0000_0300,32'h0,0,1,0,32'h0,          1,0,2,32'h0000_0300,32'h0,1,32'hCAFE_F00D);
        add(1,0,2,32'h0000_0300,32'h0,0,0,1,32'h0BAD_F00D,  0,0,2,32'h0000_0300,32'h0,1,32'hCAFE_F00D);
        add(1,0,2,32'h0000_0300,32'h0,0,0,0,32'h0,          0,0,2,32'h0000_0300,32'h0,0,32'h0BAD_F00D);
        add(0,1,1,32'h0000_0302,32'h1234,0,1,0,32'h0,       1,1,1,32'h0000_0302,32'h1234_1234,1,32'h0BAD_F00D);
        add(0,1,1,32'h0000_0302,32'h1234,0,0,1,32'h0,       0,1,1,32'h0000_0302,32'h1234_1234,1,32'h0BAD_F00D);
        add(0,1,1,32'h0000_0302,32'h1234,0,0,0,32'h0,       0,1,1,32'h0000_0302,32'h1234_1234,0,32'h0BAD_F00D);
        // No access: outputs keep latched fields, handshakes ignored
        add(0,0,2,32'hFFFF_0000,32'hABCD,0,1,1,32'h5555_5555,0,1,1,32'h0000_0302,32'h1234_1234,0,32'h0BAD_F00D);

        // Reset state
        rst = 1'b1;
        drive(0,0,0,32'h0,32'h0,0,0,0,32'h0);
        #3;
        check_all(-1, 0,0,0,32'h0,32'h0,0,32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table-driven cycles
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                  vecs[i].ext, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            @(negedge clk);
            check_all(i, vecs[i].e_req, vecs[i].e_wr, vecs[i].e_size, vecs[i].e_addr,
                      vecs[i].e_wdata, vecs[i].e_stall, vecs[i].e_rdm);
            @(posedge clk);
            #1;
        end

        // Reset pulsed in WAIT, then a late data_ok
        drive(1,0,2,32'h0000_0400,32'h0,0,1,0,32'h0);
        @(negedge clk);
        check("rst_seq_issue_req", 100, {31'd0, data_req}, 32'd1);
        @(posedge clk);
        #1;
        drive(1,0,2,32'h0000_0400,32'h0,0,0,0,32'h0);
        #1;
        check("rst_seq_wait_stall", 101, {31'd0, d_cache_stall}, 32'd1);
        check("rst_seq_wait_req",   101, {31'd0, data_req},      32'd0);
        drive(0,0,0,32'h0,32'h0,0,0,0,32'h0);
        rst = 1'b1;
        #1;
        check_all(102, 0,0,0,32'h0,32'h0,0,32'h0);
        #2 rst = 1'b0;
        drive(0,0,0,32'h0,32'h0,0,0,1,32'h9999_9999);
        @(posedge clk);
        #1;
        check_all(103, 0,0,0,32'h0,32'h0,0,32'h0);
        @(posedge clk);
        #1;
        drive(0,0,0,32'h0,32'h0,0,0,0,32'h0);
        check("rst_seq_rdata_kept_zero", 104, mem_rdataM, 32'h0);

        // Ten idle cycles with handshake noise
        for (int k = 0; k < 10; k++) begin
            drive(0,0,2'($urandom_range(0,3)),$urandom,$urandom,1'($urandom_range(0,1)),
                  1'($urandom_range(0,1)),1'($urandom_range(0,1)),$urandom);
            @(negedge clk);
            check("idle_noise_req",   200 + k, {31'd0, data_req},      32'd0);
            check("idle_noise_stall", 200 + k, {31'd0, d_cache_stall}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("idle_noise_rdata", 210, mem_rdataM, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_d_mem_ctrl
`default_nettype wire
